// File: rtl/mem_dev_bridge.sv
// mem_dev_bridge: MEM-stage data-side responder. Decodes each load/store into data memory or
// one of two timer devices, runs a registered request/ready handshake to the chosen target and
// stalls the pipeline until the target answers, then returns read data or an address error.
//
// Optional feature: define MEM_DEV_BRIDGE_TIMEOUT_EN to abort a BUSY wait after TIMEOUT_CYC
// cycles without dev_ready. When undefined, BUSY waits indefinitely.

module mem_dev_bridge #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [31:0] DM_TOP      = 32'h0000_2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  input  logic        flush,
  output logic        cpu_stall,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_addr_err,
  output logic        dev_req,
  output logic [1:0]  dev_sel,
  output logic        dev_we,
  output logic [3:0]  dev_be,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  input  logic [31:0] dev_rdata,
  input  logic        dev_ready
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam logic [31:0] Timer0First = 32'h0000_7F00;
  localparam logic [31:0] Timer0Last  = 32'h0000_7F0B;
  localparam logic [31:0] Timer1First = 32'h0000_7F10;
  localparam logic [31:0] Timer1Last  = 32'h0000_7F1B;

  localparam logic [1:0] SelDm     = 2'b00;
  localparam logic [1:0] SelTimer0 = 2'b01;
  localparam logic [1:0] SelTimer1 = 2'b10;

  state_e      state_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        hit_dm;
  logic        hit_t0;
  logic        hit_t1;
  logic        hit_timer;
  logic        dec_err;
  logic [1:0]  dec_sel;

`ifdef MEM_DEV_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

  logic [CntW-1:0] cnt_q;
`endif

  // Address decode of the live CPU request; only acted upon in IDLE.
  always_comb begin
    hit_dm    = (cpu_addr <= DM_TOP);
    hit_t0    = (cpu_addr >= Timer0First) && (cpu_addr <= Timer0Last);
    hit_t1    = (cpu_addr >= Timer1First) && (cpu_addr <= Timer1Last);
    hit_timer = hit_t0 || hit_t1;
    dec_err   = 1'b0;
    if (!hit_dm && !hit_timer) begin
      dec_err = 1'b1;
    end else if (hit_timer && (cpu_be != 4'b1111)) begin
      // Timer registers are word-only.
      dec_err = 1'b1;
    end else if (hit_timer && cpu_we && (cpu_addr[3:2] == 2'b10)) begin
      // Offset 0x8 is the read-only count register.
      dec_err = 1'b1;
    end
    if (hit_t1) begin
      dec_sel = SelTimer1;
    end else if (hit_t0) begin
      dec_sel = SelTimer0;
    end else begin
      dec_sel = SelDm;
    end
  end

  // Transaction FSM with registered device-side outputs and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      dev_req   <= 1'b0;
      dev_sel   <= '0;
      dev_we    <= 1'b0;
      dev_be    <= '0;
      dev_addr  <= '0;
      dev_wdata <= '0;
`ifdef MEM_DEV_BRIDGE_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_req && !flush) begin
            if (dec_err) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= StDone;
            end else begin
              dev_req   <= 1'b1;
              dev_sel   <= dec_sel;
              dev_we    <= cpu_we;
              dev_be    <= cpu_be;
              dev_addr  <= cpu_addr;
              dev_wdata <= cpu_wdata;
              err_q     <= 1'b0;
              rdata_q   <= '0;
              state_q   <= StBusy;
`ifdef MEM_DEV_BRIDGE_TIMEOUT_EN
              cnt_q     <= '0;
`endif
            end
          end
        end
        StBusy: begin
          // flush is deliberately ignored: an issued access always completes.
          if (dev_ready) begin
            rdata_q <= dev_we ? 32'h0 : dev_rdata;
            err_q   <= 1'b0;
            dev_req <= 1'b0;
            state_q <= StDone;
          end
`ifdef MEM_DEV_BRIDGE_TIMEOUT_EN
          else if (cnt_q == CntMax) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            dev_req <= 1'b0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // CPU-side outputs; the ack is suppressed by a flush but the FSM still leaves DONE.
  always_comb begin
    cpu_stall    = cpu_req && (state_q != StDone);
    cpu_ack      = (state_q == StDone) && !flush;
    cpu_rdata    = rdata_q;
    cpu_addr_err = err_q;
  end

endmodule

// File: tb/tb_mem_dev_bridge.sv
// Self-checking bench for mem_dev_bridge: directed scenarios plus randomized transactions,
// checked against a transaction-level model of decode, latency and response data.
// Define MEM_DEV_BRIDGE_TIMEOUT_EN to also exercise the timeout path.

module tb_mem_dev_bridge;

  localparam int unsigned TimeoutCyc = 16;
  localparam logic [31:0] DmTop      = 32'h0000_2FFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic        flush;
  logic        cpu_stall;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_addr_err;
  logic        dev_req;
  logic [1:0]  dev_sel;
  logic        dev_we;
  logic [3:0]  dev_be;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [31:0] dev_rdata;
  logic        dev_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_dev_bridge #(
    .TIMEOUT_CYC(TimeoutCyc),
    .DM_TOP     (DmTop)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_be      (cpu_be),
    .cpu_wdata   (cpu_wdata),
    .flush       (flush),
    .cpu_stall   (cpu_stall),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .cpu_addr_err(cpu_addr_err),
    .dev_req     (dev_req),
    .dev_sel     (dev_sel),
    .dev_we      (dev_we),
    .dev_be      (dev_be),
    .dev_addr    (dev_addr),
    .dev_wdata   (dev_wdata),
    .dev_rdata   (dev_rdata),
    .dev_ready   (dev_ready)
  );

  // Reference decode: address windows, word-only timers, read-only count register at offset 8.
  function automatic void model_decode(input logic we, input logic [31:0] addr,
                                       input logic [3:0] be, output logic err,
                                       output logic [1:0] sel);
    err = 1'b0;
    sel = 2'd0;
    if (addr <= DmTop) begin
      sel = 2'd0;
    end else if (addr >= 32'h7F00 && addr <= 32'h7F0B) begin
      sel = 2'd1;
      if (be != 4'hF || (we && (addr - 32'h7F00) >= 8)) err = 1'b1;
    end else if (addr >= 32'h7F10 && addr <= 32'h7F1B) begin
      sel = 2'd2;
      if (be != 4'hF || (we && (addr - 32'h7F10) >= 8)) err = 1'b1;
    end else begin
      err = 1'b1;
    end
  endfunction

  // One complete transaction. mode: 0 plain, 1 flush during first BUSY cycle, 2 flush on ack.
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] rd,
                         input int waits, input int mode);
    logic        m_err;
    logic [1:0]  m_sel;
    logic        timed_out;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_ack;
    int          exp_busy;
    int          cyc;
    int          busy;
    bit          done;

    model_decode(we, addr, be, m_err, m_sel);
`ifdef MEM_DEV_BRIDGE_TIMEOUT_EN
    timed_out = !m_err && (waits > int'(TimeoutCyc));
`else
    timed_out = 1'b0;
`endif
    exp_err   = m_err || timed_out;
    exp_rdata = (exp_err || we) ? 32'h0 : rd;
    exp_ack   = m_err ? 1 : (timed_out ? int'(TimeoutCyc) + 2 : waits + 2);
    exp_busy  = m_err ? 0 : (timed_out ? int'(TimeoutCyc) + 1 : waits + 1);

    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_be    = be;
    cpu_wdata = wdata;
    dev_ready = 1'b0;
    #1;
    n_checks++;
    if (cpu_stall !== 1'b1 || cpu_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL %s cycle0 stall/ack: got %b/%b want 1/0", name, cpu_stall, cpu_ack);
    end

    cyc  = 0;
    busy = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      flush     = 1'b0;
      dev_ready = 1'b0;
      #1;
      cyc++;
      if (dev_req === 1'b1) begin
        busy++;
        n_checks++;
        if ({dev_sel, dev_we, dev_be, dev_addr, dev_wdata} !== {m_sel, we, be, addr, wdata}) begin
          n_fail++;
          $display("FAIL %s dev_fields: got sel=%0d we=%b be=%h addr=%h wd=%h want sel=%0d we=%b be=%h addr=%h wd=%h",
                   name, dev_sel, dev_we, dev_be, dev_addr, dev_wdata, m_sel, we, be, addr, wdata);
        end
        if (busy == waits + 1) begin
          dev_ready = 1'b1;
          dev_rdata = rd;
        end else begin
          dev_rdata = $urandom;
        end
        if (mode == 1 && busy == 1) flush = 1'b1;
      end
      if (cyc == exp_ack) begin
        done = 1'b1;
        if (mode == 2) begin
          flush = 1'b1;
          #1;
          n_checks++;
          if (cpu_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL %s flushed_ack: got %b want 0", name, cpu_ack);
          end
        end else begin
          n_checks++;
          if (cpu_ack !== 1'b1 || cpu_stall !== 1'b0 || cpu_addr_err !== exp_err ||
              cpu_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s ack@%0d: got ack=%b stall=%b err=%b rdata=%h want 1/0 err=%b rdata=%h",
                     name, cyc, cpu_ack, cpu_stall, cpu_addr_err, cpu_rdata, exp_err, exp_rdata);
          end
        end
      end else begin
        n_checks++;
        if (cpu_ack !== 1'b0 || cpu_stall !== 1'b1) begin
          n_fail++;
          $display("FAIL %s wait@%0d ack/stall: got %b/%b want 0/1", name, cyc, cpu_ack, cpu_stall);
        end
      end
    end
    n_checks++;
    if (busy != exp_busy) begin
      n_fail++;
      $display("FAIL %s dev_req_cycles: got %0d want %0d", name, busy, exp_busy);
    end
    @(posedge clk);
    #1;
    flush     = 1'b0;
    cpu_req   = 1'b0;
    dev_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_be    = '0;
    cpu_wdata = '0;
    flush     = 1'b0;
    dev_rdata = '0;
    dev_ready = 1'b0;
    #12;
    n_checks++;
    if ({cpu_stall, cpu_ack, cpu_rdata, cpu_addr_err, dev_req, dev_sel, dev_we, dev_be,
         dev_addr, dev_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ack=%b err=%b req=%b addr=%h want all 0",
               cpu_ack, cpu_addr_err, dev_req, dev_addr);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_directed();
    run_txn("dm_load", 1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 0);
    run_txn("t0_store", 1'b1, 32'h0000_7F04, 4'hF, 32'h64, 32'h1234_5678, 3, 0);
    run_txn("t0_count_store", 1'b1, 32'h0000_7F08, 4'hF, 32'h5, 32'h0, 0, 0);
    run_txn("t0_byte_store", 1'b1, 32'h0000_7F00, 4'b0001, 32'h7, 32'h0, 0, 0);
    run_txn("unmapped_load", 1'b0, 32'h0000_4000, 4'hF, 32'h0, 32'h0, 0, 0);
    run_txn("dm_top_load", 1'b0, DmTop, 4'b1000, 32'h0, 32'hA5A5_0001, 1, 0);
    run_txn("dm_top_plus1", 1'b0, DmTop + 32'h1, 4'hF, 32'h0, 32'h0, 0, 0);
    run_txn("t1_last_load", 1'b0, 32'h0000_7F18, 4'hF, 32'h0, 32'h0BAD_F00D, 2, 0);
    run_txn("t1_count_load", 1'b0, 32'h0000_7F18, 4'hF, 32'h0, 32'h0000_0042, 0, 0);
    run_txn("t0_gap", 1'b0, 32'h0000_7F0C, 4'hF, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_flush();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0100;
    cpu_be   = 4'hF;
    flush    = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2;
      n_checks++;
      if (dev_req !== 1'b0 || cpu_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_idle: got req=%b ack=%b want 0/0", dev_req, cpu_ack);
      end
    end
    cpu_req = 1'b0;
    flush   = 1'b0;
    @(posedge clk);
    #1;
    run_txn("flush_busy", 1'b0, 32'h0000_0200, 4'hF, 32'h0, 32'hCAFE_0001, 2, 1);
    run_txn("flush_done", 1'b0, 32'h0000_0204, 4'hF, 32'h0, 32'hCAFE_0002, 1, 2);
    run_txn("after_flush", 1'b0, 32'h0000_0208, 4'hF, 32'h0, 32'hCAFE_0003, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_a", 1'b1, 32'h0000_0300, 4'b0011, 32'h1111_2222, 32'h0, 0, 0);
    run_txn("b2b_b", 1'b0, 32'h0000_7F14, 4'hF, 32'h0, 32'h3333_4444, 0, 0);
    run_txn("b2b_c", 1'b0, 32'h0000_9000, 4'hF, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_reset_mid_busy();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h0000_0040;
    cpu_be    = 4'hF;
    cpu_wdata = 32'h5555_AAAA;
    dev_ready = 1'b0;
    @(posedge clk);
    #2;
    n_checks++;
    if (dev_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy_req: got %b want 1", dev_req);
    end
    reset   = 1'b0;
    cpu_req = 1'b0;
    #1;
    n_checks++;
    if ({cpu_stall, cpu_ack, cpu_rdata, cpu_addr_err, dev_req, dev_sel, dev_we, dev_be,
         dev_addr, dev_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: got req=%b we=%b addr=%h wd=%h want all 0",
               dev_req, dev_we, dev_addr, dev_wdata);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_txn("after_reset", 1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0]  b;
    for (int i = 0; i < 40; i++) begin
      b = 4'hF;
      case ($urandom_range(0, 4))
        0: begin
          a = $urandom_range(0, int'(DmTop));
          b = 4'($urandom_range(1, 15));
        end
        1: a = 32'h7F00 + 32'(4 * $urandom_range(0, 2));
        2: a = 32'h7F10 + 32'(4 * $urandom_range(0, 2));
        3: a = DmTop + 32'($urandom_range(1, 32'h5000));
        default: a = $urandom;
      endcase
      if ((a >= 32'h7F00) && ($urandom_range(0, 3) == 0)) b = 4'($urandom_range(0, 14));
      run_txn("random", 1'($urandom_range(0, 1)), a, b, $urandom, $urandom,
              $urandom_range(0, 4), ($urandom_range(0, 5) == 0) ? 1 : 0);
    end
  endtask

`ifdef MEM_DEV_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    run_txn("timeout", 1'b0, 32'h0000_0020, 4'hF, 32'h0, 32'h7777_7777, 1000, 0);
    run_txn("ready_on_timeout", 1'b0, 32'h0000_0024, 4'hF, 32'h0, 32'h8888_8888,
            int'(TimeoutCyc), 0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
`ifdef MEM_DEV_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
